reduction_gate_pipelined: RTL and testbench

Parametrised, pipelined N-input reduction gate with per-input bubbles, runtime-selectable reduction mode (OR/AND/XOR/majority), output inversion, a population count and a sticky accumulator. It generalises the fixed 17-input bubbled gates used in the recognition datapath. It serves wide feature-map "any/all/parity/majority" decisions where a flat combinational gate would limit Fmax.

---
 rtl/reduction_gate_pipelined.sv | 151 +++++++++++++++
 tb/tb_reduction_gate_pipelined.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reduction_gate_pipelined.sv
// Pipelined N-input bubbled reduction gate: grouped partials in stage 1,
// mode select / invert / popcount / sticky accumulator in stage 2.
module reduction_gate_pipelined #(
    parameter int NR_OF_INPUTS = 17,
    parameter int GROUP_SIZE = 4,
    parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
    localparam int CNT_WIDTH = $clog2(NR_OF_INPUTS + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Tick,
    input  logic                    In_Valid,
    input  logic [NR_OF_INPUTS-1:0] Data_In,
    input  logic [1:0]              Mode,
    input  logic                    Invert,
    input  logic                    Acc_En,
    input  logic                    Acc_Clear,
    output logic                    Out_Valid,
    output logic                    Result,
    output logic [CNT_WIDTH-1:0]    Ones_Count,
    output logic                    Acc_Result
);

    localparam int NG = (NR_OF_INPUTS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int PADW = NG * GROUP_SIZE;
    localparam int GCW = $clog2(GROUP_SIZE + 1);
    localparam int TW = CNT_WIDTH + 1;
    localparam int DW = TW + 1;
    localparam logic [PADW-1:0] VALID_M = PADW'({NR_OF_INPUTS{1'b1}});

    function automatic logic [GCW-1:0] pop(input logic [GROUP_SIZE-1:0] v);
        logic [GCW-1:0] c;
        c = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            c = c + GCW'(v[i]);
        end
        return c;
    endfunction

    logic [NR_OF_INPUTS-1:0] b;
    logic [PADW-1:0] b_zero;
    logic [PADW-1:0] b_one;

    // Padding is 0 for OR/XOR/count and 1 for AND so short groups are neutral.
    assign b      = Data_In ^ BUBBLES_MASK;
    assign b_zero = PADW'(b);
    assign b_one  = b_zero | ~VALID_M;

    logic [NG-1:0]          or_d, and_d, xor_d;
    logic [NG-1:0][GCW-1:0] cnt_d;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign or_d[g]  = |b_zero[g*GROUP_SIZE +: GROUP_SIZE];
        assign and_d[g] = &b_one[g*GROUP_SIZE +: GROUP_SIZE];
        assign xor_d[g] = ^b_zero[g*GROUP_SIZE +: GROUP_SIZE];
        assign cnt_d[g] = pop(b_zero[g*GROUP_SIZE +: GROUP_SIZE]);
    end

    logic                   s1_valid_q;
    logic [1:0]             s1_mode_q;
    logic                   s1_inv_q;
    logic                   s1_acc_en_q;
    logic [NG-1:0]          or_q, and_q, xor_q;
    logic [NG-1:0][GCW-1:0] cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= '0;
            s1_inv_q    <= 1'b0;
            s1_acc_en_q <= 1'b0;
            or_q        <= '0;
            and_q       <= '0;
            xor_q       <= '0;
            cnt_q       <= '0;
        end else if (Tick) begin
            s1_valid_q  <= In_Valid;
            s1_mode_q   <= Mode;
            s1_inv_q    <= Invert;
            s1_acc_en_q <= Acc_En;
            or_q        <= or_d;
            and_q       <= and_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
        end
    end

    logic [TW-1:0] tot_d;
    logic [DW-1:0] dbl;
    logic          maj;
    logic          raw;
    logic          res_d;
    logic          acc_d;

    always_comb begin
        tot_d = '0;
        for (int g = 0; g < NG; g++) begin
            tot_d = tot_d + TW'(cnt_q[g]);
        end
    end

    // Majority is strict: a tie is not a majority.
    assign dbl = {tot_d, 1'b0};
    assign maj = dbl > DW'(NR_OF_INPUTS);

    always_comb begin
        raw = 1'b0;
        unique case (s1_mode_q)
            2'b00:   raw = |or_q;
            2'b01:   raw = &and_q;
            2'b10:   raw = ^xor_q;
            2'b11:   raw = maj;
            default: raw = 1'b0;
        endcase
    end

    assign res_d = raw ^ s1_inv_q;
    assign acc_d = (Acc_Clear ? 1'b0 : Acceptor_q())
                 | (s1_valid_q & s1_acc_en_q & res_d);

    logic                 out_valid_q;
    logic                 result_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 acc_q;

    function automatic logic Acceptor_q();
        return acc_q;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            count_q     <= '0;
            acc_q       <= 1'b0;
        end else if (Tick) begin
            out_valid_q <= s1_valid_q;
            acc_q       <= acc_d;
            if (s1_valid_q) begin
                result_q <= res_d;
                count_q  <= tot_d[CNT_WIDTH-1:0];
            end
        end
    end

    assign Out_Valid  = out_valid_q;
    assign Result     = result_q;
    assign Ones_Count = count_q;
    assign Acc_Result = acc_q;

endmodule

// File: tb/tb_reduction_gate_pipelined.sv
// Directed bench: vector table for both bubble masks plus stall,
// accumulator and reset-in-flight sequences.
module tb_reduction_gate_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        in_valid;
    logic [16:0] data_in;
    logic [1:0]  mode;
    logic        invert;
    logic        acc_en;
    logic        acc_clear;

    logic        oa_valid, ob_valid;
    logic        oa_res, ob_res;
    logic [4:0]  oa_cnt, ob_cnt;
    logic        oa_acc, ob_acc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reduction_gate_pipelined u_dut_a (
        .Clock(clk), .Reset(rst), .Tick(tick), .In_Valid(in_valid),
        .Data_In(data_in), .Mode(mode), .Invert(invert),
        .Acc_En(acc_en), .Acc_Clear(acc_clear),
        .Out_Valid(oa_valid), .Result(oa_res),
        .Ones_Count(oa_cnt), .Acc_Result(oa_acc)
    );

    reduction_gate_pipelined #(
        .BUBBLES_MASK(17'h00001)
    ) u_dut_b (
        .Clock(clk), .Reset(rst), .Tick(tick), .In_Valid(in_valid),
        .Data_In(data_in), .Mode(mode), .Invert(invert),
        .Acc_En(acc_en), .Acc_Clear(acc_clear),
        .Out_Valid(ob_valid), .Result(ob_res),
        .Ones_Count(ob_cnt), .Acc_Result(ob_acc)
    );

    typedef struct {
        logic [16:0] d;
        logic [1:0]  m;
        logic        inv;
        logic        ra;
        logic [4:0]  ca;
        logic        rb;
        logic [4:0]  cb;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [16:0] d,
                        input logic [1:0] m, input logic inv,
                        input logic ae, input logic clr);
        in_valid  = v;
        data_in   = d;
        mode      = m;
        invert    = inv;
        acc_en    = ae;
        acc_clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{17'h00000, 2'b00, 1'b0, 1'b0, 5'd0,  1'b1, 5'd1};
        vt[1]  = '{17'h10000, 2'b00, 1'b0, 1'b1, 5'd1,  1'b1, 5'd2};
        vt[2]  = '{17'h00007, 2'b10, 1'b0, 1'b1, 5'd3,  1'b0, 5'd2};
        vt[3]  = '{17'h00007, 2'b10, 1'b1, 1'b0, 5'd3,  1'b1, 5'd2};
        vt[4]  = '{17'h000FF, 2'b11, 1'b0, 1'b0, 5'd8,  1'b0, 5'd7};
        vt[5]  = '{17'h001FF, 2'b11, 1'b0, 1'b1, 5'd9,  1'b0, 5'd8};
        vt[6]  = '{17'h1FFFF, 2'b11, 1'b0, 1'b1, 5'd17, 1'b1, 5'd16};
        vt[7]  = '{17'h1FFFF, 2'b01, 1'b0, 1'b1, 5'd17, 1'b0, 5'd16};
        vt[8]  = '{17'h1FFFF, 2'b00, 1'b1, 1'b0, 5'd17, 1'b0, 5'd16};
        vt[9]  = '{17'h1FFFE, 2'b01, 1'b0, 1'b0, 5'd16, 1'b1, 5'd17};
        vt[10] = '{17'h1FFFF, 2'b10, 1'b0, 1'b1, 5'd17, 1'b0, 5'd16};

        rst = 1'b1;
        tick = 1'b1;
        step(0, '0, 2'b00, 0, 0, 0);
        step(0, '0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        step(0, '0, 2'b00, 0, 0, 0);
        chk("rst_valid", oa_valid, 0);
        chk("rst_res", oa_res, 0);
        chk("rst_cnt", oa_cnt, 0);
        chk("rst_acc", oa_acc, 0);
        chk("rst_valid_b", ob_valid, 0);

        for (int k = 0; k <= NV; k++) begin
            if (k < NV)
                step(1, vt[k].d, vt[k].m, vt[k].inv, 0, 0);
            else
                step(0, '0, 2'b00, 0, 0, 0);
            if (k >= 1) begin
                chk($sformatf("vec%0d_valid", k-1), oa_valid, 1);
                chk($sformatf("vec%0d_res_a", k-1), oa_res, vt[k-1].ra);
                chk($sformatf("vec%0d_cnt_a", k-1), oa_cnt, vt[k-1].ca);
                chk($sformatf("vec%0d_res_b", k-1), ob_res, vt[k-1].rb);
                chk($sformatf("vec%0d_cnt_b", k-1), ob_cnt, vt[k-1].cb);
            end
        end
        step(0, '0, 2'b00, 0, 0, 0);
        chk("idle_valid", oa_valid, 0);
        chk("idle_hold_res", oa_res, 1);
        chk("idle_hold_cnt", oa_cnt, 17);
        chk("idle_acc", oa_acc, 0);

        step(1, 17'h00000, 2'b00, 0, 1, 0);
        step(1, 17'h10000, 2'b00, 0, 1, 0);
        chk("acc0_res", oa_res, 0);
        chk("acc0_acc", oa_acc, 0);
        step(1, 17'h00000, 2'b00, 0, 1, 0);
        chk("acc1_res", oa_res, 1);
        chk("acc1_acc", oa_acc, 1);
        step(0, '0, 2'b00, 0, 0, 0);
        chk("acc2_res", oa_res, 0);
        chk("acc2_acc", oa_acc, 1);
        step(1, 17'h00000, 2'b00, 0, 1, 0);
        chk("clr0_pre_acc", oa_acc, 1);
        step(0, '0, 2'b00, 0, 0, 1);
        chk("clr0_valid", oa_valid, 1);
        chk("clr0_acc", oa_acc, 0);
        step(1, 17'h10000, 2'b00, 0, 1, 0);
        step(0, '0, 2'b00, 0, 0, 1);
        chk("clr1_acc", oa_acc, 1);

        step(1, 17'h00000, 2'b01, 0, 0, 0);
        chk("stall_s1_valid", oa_valid, 0);
        tick = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(0, '0, 2'b00, 0, 0, 1);
            chk($sformatf("stall%0d_valid", c), oa_valid, 0);
            chk($sformatf("stall%0d_res", c), oa_res, 1);
            chk($sformatf("stall%0d_acc", c), oa_acc, 1);
        end
        tick = 1'b1;
        step(0, '0, 2'b00, 0, 0, 0);
        chk("stall_out_valid", oa_valid, 1);
        chk("stall_out_res", oa_res, 0);
        chk("stall_out_cnt", oa_cnt, 0);
        chk("stall_out_acc", oa_acc, 1);

        step(1, 17'h10000, 2'b00, 0, 1, 0);
        step(1, 17'h10000, 2'b00, 0, 1, 0);
        chk("flight_valid", oa_valid, 1);
        rst = 1'b1;
        tick = 1'b0;
        step(0, '0, 2'b00, 0, 0, 0);
        chk("rst_t0_valid", oa_valid, 0);
        chk("rst_t0_res", oa_res, 0);
        chk("rst_t0_cnt", oa_cnt, 0);
        chk("rst_t0_acc", oa_acc, 0);
        rst = 1'b0;
        tick = 1'b1;
        step(0, '0, 2'b00, 0, 0, 0);
        chk("post_rst0_valid", oa_valid, 0);
        step(1, 17'h00007, 2'b10, 0, 0, 0);
        chk("post_rst1_valid", oa_valid, 0);
        chk("post_rst1_acc", oa_acc, 0);
        step(0, '0, 2'b00, 0, 0, 0);
        chk("post_rst_valid", oa_valid, 1);
        chk("post_rst_res", oa_res, 1);
        chk("post_rst_cnt", oa_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
